// File: rtl/monobit_test_ctrl_pkg.sv
// Shared types and constants for the monobit health-test controller.
// Holds the vector width, the controller state encoding and the result-width helper.
package keygen_pkg;

    localparam int VEC_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FINAL   = 2'd2,
        DONE    = 2'd3
    } mono_state_t;

    // Width needed to hold an all-ones window of nb vectors without overflow.
    function automatic int tot_width(input int nb);
        return $clog2(nb * VEC_W + 1);
    endfunction

endpackage

// File: rtl/monobit_test_ctrl_if.sv
// Control, entropy-beat and result signals of the monobit health test.
// master drives start/abort/beats; slave is the controller.
interface monobit_test_ctrl_if
    import keygen_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int NUM_BLOCKS = 16
);
    localparam int TOT_W = tot_width(NUM_BLOCKS);

    logic             start;
    logic             abort;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [TOT_W-1:0] ones_total;

    modport master (
        output start, abort, in_valid, in_data,
        input  in_ready, busy, done, pass, ones_total
    );

    modport slave (
        input  start, abort, in_valid, in_data,
        output in_ready, busy, done, pass, ones_total
    );

endinterface

// File: rtl/monobit_test_ctrl_sum_tree.sv
// sum_tree: combinational population count of one 128-bit vector.
// Result range 0..128 fits the 8-bit output.
module sum_tree
    import keygen_pkg::*;
(
    input  logic [VEC_W-1:0] in_vector,
    output logic [7:0]       out_sum
);

    always_comb begin
        out_sum = '0;
        for (int i = 0; i < VEC_W; i++) begin
            out_sum = out_sum + 8'(in_vector[i]);
        end
    end

endmodule

// File: rtl/monobit_test_ctrl.sv
// Monobit/frequency health test: packs entropy beats into 128-bit vectors, counts ones over a window
// and flags pass against [LO_THR,HI_THR]. Define MONOBIT_CONTINUOUS_EN for back-to-back windows.
module monobit_test_ctrl
    import keygen_pkg::*;
#(
    parameter int IN_W       = 8,
    parameter int NUM_BLOCKS = 16,
    parameter int LO_THR     = 954,
    parameter int HI_THR     = 1094
) (
    input logic                clk,
    input logic                rst,
    monobit_test_ctrl_if.slave bus
);

    localparam int TOT_W = tot_width(NUM_BLOCKS);
    localparam int BEATS = VEC_W / IN_W;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int KC_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    mono_state_t      state_q, state_d;
    logic [VEC_W-1:0] shreg_q, shreg_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [BC_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [KC_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic             vec_vld_q, vec_vld_d;
    logic [TOT_W-1:0] acc_q, acc_d;
    logic [TOT_W-1:0] ones_total_q, ones_total_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic [7:0]       out_sum;
    logic [TOT_W-1:0] acc_sum;
    logic             hs;
    logic             last_beat;
    logic             last_blk;

    function automatic logic in_window(input logic [TOT_W-1:0] t);
        return (32'(t) >= 32'(LO_THR)) && (32'(t) <= 32'(HI_THR));
    endfunction

    sum_tree u_sum_tree (
        .in_vector (vec_q),
        .out_sum   (out_sum)
    );

    always_comb begin
        hs        = bus.in_valid && (state_q == COLLECT);
        last_beat = (beat_cnt_q == BC_W'(BEATS - 1));
        last_blk  = (blk_cnt_q == KC_W'(NUM_BLOCKS - 1));
        acc_sum   = acc_q + (vec_vld_q ? TOT_W'(out_sum) : '0);

        state_d      = state_q;
        shreg_d      = shreg_q;
        vec_d        = vec_q;
        beat_cnt_d   = beat_cnt_q;
        blk_cnt_d    = blk_cnt_q;
        vec_vld_d    = 1'b0;
        acc_d        = acc_sum;
        ones_total_d = ones_total_q;
        done_d       = 1'b0;
        pass_d       = pass_q;

        // abort drops the window but keeps the previously published result
        if (bus.abort) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            blk_cnt_d  = '0;
            acc_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) state_d = COLLECT;
                end
                COLLECT: begin
                    if (hs) begin
                        shreg_d    = (shreg_q << IN_W) | VEC_W'(bus.in_data);
                        beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
                        if (last_beat) begin
                            vec_d     = shreg_d;
                            vec_vld_d = 1'b1;
                            blk_cnt_d = last_blk ? '0 : blk_cnt_q + 1'b1;
                            if (last_blk) state_d = FINAL;
                        end
                    end
                end
                FINAL: begin
                    // last vector is summed here; the result is published as DONE begins
                    state_d      = DONE;
                    done_d       = 1'b1;
                    ones_total_d = acc_sum;
                    pass_d       = in_window(acc_sum);
                    acc_d        = '0;
                end
                DONE: begin
`ifdef MONOBIT_CONTINUOUS_EN
                    state_d = COLLECT;
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            beat_cnt_q   <= '0;
            blk_cnt_q    <= '0;
            vec_vld_q    <= 1'b0;
            acc_q        <= '0;
            ones_total_q <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            beat_cnt_q   <= beat_cnt_d;
            blk_cnt_q    <= blk_cnt_d;
            vec_vld_q    <= vec_vld_d;
            acc_q        <= acc_d;
            ones_total_q <= ones_total_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    // vec_q is only consumed while vec_vld_q is set, so it needs no reset
    always_ff @(posedge clk) begin
        vec_q <= vec_d;
    end

    assign bus.in_ready   = (state_q == COLLECT);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.ones_total = ones_total_q;

endmodule

// File: tb/tb_monobit_test_ctrl.sv
// Directed bench for monobit_test_ctrl at IN_W=8, NUM_BLOCKS=16: table of windows plus
// abort/reset sequences. Also valid with MONOBIT_CONTINUOUS_EN defined.
module tb_monobit_test_ctrl;

`ifdef MONOBIT_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    localparam int NWIN = 10;

    typedef struct {
        string      name;
        logic [7:0] a;
        int         na;
        logic [7:0] b;
        int         nb;
        logic [7:0] c;
        int         exp_total;
        bit         exp_pass;
        bit         gaps;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    monobit_test_ctrl_if #(.IN_W(8), .NUM_BLOCKS(16)) bus ();

    monobit_test_ctrl #(
        .IN_W       (8),
        .NUM_BLOCKS (16),
        .LO_THR     (954),
        .HI_THR     (1094)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] beat_of(input win_t w, input int i);
        if (i < w.na) return w.a;
        if (i < w.na + w.nb) return w.b;
        return w.c;
    endfunction

    task automatic start_pulse();
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic feed(input win_t w, input int nbeats);
        int  i   = 0;
        int  cyc = 0;
        bit  v;
        bit  hs;
        while (i < nbeats && cyc < 4096) begin
            v            = w.gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = beat_of(w, i);
            hs           = v && (bus.in_ready === 1'b1);
            @(posedge clk);
            #1;
            if (hs) i++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (i < nbeats) check({w.name, ".feed_timeout"}, i, nbeats);
    endtask

    task automatic finish_window(input win_t w);
        check({w.name, ".done_early"}, bus.done, 0);
        check({w.name, ".rdy_final"}, bus.in_ready, 0);
        @(posedge clk);
        #1;
        check({w.name, ".done"}, bus.done, 1);
        check({w.name, ".ones_total"}, bus.ones_total, w.exp_total);
        check({w.name, ".pass"}, bus.pass, w.exp_pass);
        check({w.name, ".rdy_done"}, bus.in_ready, 0);
        @(posedge clk);
        #1;
        check({w.name, ".done_pulse"}, bus.done, 0);
        check({w.name, ".busy_after"}, bus.busy, CONT);
    endtask

    win_t tbl [NWIN];
    win_t w0f;
    win_t wff;
    int   base;

    initial begin
        tbl[0] = '{"p55",    8'h55, 256, 8'h00, 0, 8'h00, 1024, 1'b1, 1'b0};
        tbl[1] = '{"ff",     8'hFF, 256, 8'h00, 0, 8'h00, 2048, 1'b0, 1'b0};
        tbl[2] = '{"zero",   8'h00, 256, 8'h00, 0, 8'h00,    0, 1'b0, 1'b0};
        tbl[3] = '{"lo954",  8'hFF, 119, 8'h03, 1, 8'h00,  954, 1'b1, 1'b0};
        tbl[4] = '{"lo953",  8'hFF, 119, 8'h01, 1, 8'h00,  953, 1'b0, 1'b0};
        tbl[5] = '{"hi1094", 8'hFF, 136, 8'h3F, 1, 8'h00, 1094, 1'b1, 1'b0};
        tbl[6] = '{"hi1095", 8'hFF, 136, 8'h7F, 1, 8'h00, 1095, 1'b0, 1'b0};
        tbl[7] = '{"p55gap", 8'h55, 256, 8'h00, 0, 8'h00, 1024, 1'b1, 1'b1};
        tbl[8] = '{"msb80",  8'h80, 256, 8'h00, 0, 8'h00,  256, 1'b0, 1'b0};
        tbl[9] = '{"f7",     8'hF7, 256, 8'h00, 0, 8'h00, 1792, 1'b0, 1'b0};
        w0f    = '{"p0f",    8'h0F, 256, 8'h00, 0, 8'h00, 1024, 1'b1, 1'b0};
        wff    = '{"partff", 8'hFF, 256, 8'h00, 0, 8'h00, 2048, 1'b0, 1'b0};

        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.pass", bus.pass, 0);
        check("rst.ones_total", bus.ones_total, 0);
        check("rst.in_ready", bus.in_ready, 0);

        // idle: beats are refused and abort beats a simultaneous start
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        #1 check("idle.in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("abort_vs_start.busy", bus.busy, 0);
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;

        for (int k = 0; k < NWIN; k++) begin
            start_pulse();
            check({tbl[k].name, ".in_ready"}, bus.in_ready, 1);
            feed(tbl[k], 256);
            finish_window(tbl[k]);
        end

        // abort mid-window keeps the old result, then a clean window yields one done
        base = done_cnt;
        start_pulse();
        feed(wff, 100);
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        check("abort.busy", bus.busy, 0);
        check("abort.ones_total_kept", bus.ones_total, tbl[NWIN-1].exp_total);
        check("abort.pass_kept", bus.pass, tbl[NWIN-1].exp_pass);
        check("abort.done", bus.done, 0);
        start_pulse();
        feed(w0f, 256);
        finish_window(w0f);
        check("abort.done_count", done_cnt - base, 1);

        // reset mid-window clears every output
        start_pulse();
        feed(wff, 100);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst2.busy", bus.busy, 0);
        check("rst2.done", bus.done, 0);
        check("rst2.pass", bus.pass, 0);
        check("rst2.ones_total", bus.ones_total, 0);
        check("rst2.in_ready", bus.in_ready, 0);
        base = done_cnt;
        start_pulse();
        feed(w0f, 256);
        finish_window(w0f);
        check("rst2.done_count", done_cnt - base, 1);

`ifdef MONOBIT_CONTINUOUS_EN
        // back-to-back windows from a single start
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        base = done_cnt;
        start_pulse();
        feed(tbl[0], 256);
        finish_window(tbl[0]);
        feed(tbl[0], 256);
        finish_window(tbl[0]);
        check("cont.done_count", done_cnt - base, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
